// File: rtl/mem_arbiter.sv
// Two-requester (icache/dcache) arbiter in front of a single memory4c port.
// Build option: define MEM_ARB_RR_EN for round-robin contention resolution (default: icache priority).
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_ren,
  input  logic        i_wen,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_wdata,
  output logic        i_grant,
  output logic        i_valid,
  output logic [15:0] i_rdata,
  input  logic        d_ren,
  input  logic        d_wen,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_grant,
  output logic        d_valid,
  output logic [15:0] d_rdata,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_data_valid,
  output logic        err
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] I_OWN = 2'd1;
  localparam logic [1:0] D_OWN = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;
  localparam logic OWNER_I = 1'b1;
  localparam logic OWNER_D = 1'b0;

  logic [1:0] state_q, state_d;
  logic       last_q, last_d;
  logic [2:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       i_req, d_req, pick_i;
  logic       cnt_inc, cnt_dec;

  assign i_req = i_ren | i_wen;
  assign d_req = d_ren | d_wen;

`ifdef MEM_ARB_RR_EN
  assign pick_i = i_req & (~d_req | (last_q == OWNER_D));
`else
  assign pick_i = i_req;
`endif

  assign i_grant = (state_q == I_OWN);
  assign d_grant = (state_q == D_OWN);

  // A write wins over a simultaneous read from the same owner.
  always_comb begin
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    if (state_q == I_OWN) begin
      mem_wen   = i_wen;
      mem_ren   = i_ren & ~i_wen;
      mem_addr  = i_addr;
      mem_wdata = i_wdata;
    end else if (state_q == D_OWN) begin
      mem_wen   = d_wen;
      mem_ren   = d_ren & ~d_wen;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  assign cnt_inc = mem_ren & ~mem_wen;
  assign cnt_dec = mem_data_valid;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q | (mem_data_valid & (state_q == IDLE));
    if (cnt_inc && !cnt_dec) begin
      if (cnt_q == 3'd7) err_d = 1'b1;
      else               cnt_d = cnt_q + 3'd1;
    end else if (cnt_dec && !cnt_inc) begin
      if (cnt_q == 3'd0) err_d = 1'b1;
      else               cnt_d = cnt_q - 3'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (pick_i) begin
          state_d = I_OWN;
          last_d  = OWNER_I;
        end else if (d_req) begin
          state_d = D_OWN;
          last_d  = OWNER_D;
        end
      end
      I_OWN:   if (!i_req) state_d = (cnt_d == 3'd0) ? IDLE : DRAIN;
      D_OWN:   if (!d_req) state_d = (cnt_d == 3'd0) ? IDLE : DRAIN;
      default: if (cnt_d == 3'd0) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= OWNER_D;
      cnt_q   <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Returning data follows the current owner, or the previous owner while draining.
  assign i_valid = mem_data_valid &
                   ((state_q == I_OWN) | ((state_q == DRAIN) & (last_q == OWNER_I)));
  assign d_valid = mem_data_valid &
                   ((state_q == D_OWN) | ((state_q == DRAIN) & (last_q == OWNER_D)));
  assign i_rdata = i_valid ? mem_rdata : 16'h0000;
  assign d_rdata = d_valid ? mem_rdata : 16'h0000;
  assign err     = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model with a 4-cycle-latency memory.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_ren = 0, i_wen = 0, d_ren = 0, d_wen = 0;
  logic [15:0] i_addr = 0, i_wdata = 0, d_addr = 0, d_wdata = 0;
  logic        i_grant, i_valid, d_grant, d_valid;
  logic [15:0] i_rdata, d_rdata;
  logic        mem_ren, mem_wen;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = 0;
  logic        mem_data_valid = 0;
  logic        err;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_ren(i_ren), .i_wen(i_wen), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_grant(i_grant), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_grant(d_grant), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid), .err(err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: who owns the memory (0 none, 1 icache, 2 dcache, 3 draining), last winner,
  // reads in flight, sticky error; memory contents and a 4-deep return pipe.
  int          own;
  bit          last_i;
  int          cnt;
  bit          m_err;
  bit          mute;
  bit          pipe_v [4];
  logic [15:0] pipe_d [4];
  logic [15:0] mem_arr [256];

  task automatic model_reset();
    own = 0; last_i = 0; cnt = 0; m_err = 0;
    for (int k = 0; k < 4; k++) begin
      pipe_v[k] = 0;
      pipe_d[k] = 16'h0;
    end
  endtask

  task automatic step(input bit ir, input bit iw, input logic [15:0] ia, input logic [15:0] iwd,
                      input bit dr, input bit dw, input logic [15:0] da, input logic [15:0] dwd,
                      input bit spur);
    logic        e_mren, e_mwen, e_iv, e_dv, dv;
    logic [15:0] e_ma, e_mwd, rd;
    bit          ireq, dreq, owner_req;
    int          winner;
    @(negedge clk);
    i_ren = ir; i_wen = iw; i_addr = ia; i_wdata = iwd;
    d_ren = dr; d_wen = dw; d_addr = da; d_wdata = dwd;
    dv = !mute && (pipe_v[3] || spur);
    rd = pipe_v[3] ? pipe_d[3] : 16'($urandom);
    mem_data_valid = dv;
    mem_rdata = rd;
    #1;
    e_mren = 0; e_mwen = 0; e_ma = 0; e_mwd = 0;
    if (own == 1) begin
      e_mwen = iw; e_mren = ir && !iw; e_ma = ia; e_mwd = iwd;
    end else if (own == 2) begin
      e_mwen = dw; e_mren = dr && !dw; e_ma = da; e_mwd = dwd;
    end
    e_iv = dv && (own == 1 || (own == 3 && last_i));
    e_dv = dv && (own == 2 || (own == 3 && !last_i));
    check_val("i_grant", {31'b0, i_grant}, {31'b0, own == 1});
    check_val("d_grant", {31'b0, d_grant}, {31'b0, own == 2});
    check_val("mem_ctl", {30'b0, mem_ren, mem_wen}, {30'b0, e_mren, e_mwen});
    check_val("mem_addr", {16'b0, mem_addr}, {16'b0, e_ma});
    check_val("mem_wdata", {16'b0, mem_wdata}, {16'b0, e_mwd});
    check_val("valids", {30'b0, i_valid, d_valid}, {30'b0, e_iv, e_dv});
    check_val("rdata", {i_rdata, d_rdata}, {e_iv ? rd : 16'h0, e_dv ? rd : 16'h0});
    check_val("err", {31'b0, err}, {31'b0, m_err});
    @(posedge clk);
    if (e_mwen) mem_arr[e_ma[7:0]] = e_mwd;
    for (int k = 3; k > 0; k--) begin
      pipe_v[k] = pipe_v[k-1];
      pipe_d[k] = pipe_d[k-1];
    end
    pipe_v[0] = e_mren;
    pipe_d[0] = mem_arr[e_ma[7:0]];
    if (own == 0 && dv) m_err = 1;
    if (e_mren && !dv) begin
      if (cnt == 7) m_err = 1; else cnt++;
    end else if (dv && !e_mren) begin
      if (cnt == 0) m_err = 1; else cnt--;
    end
    ireq = ir || iw;
    dreq = dr || dw;
    if (own == 0) begin
      winner = 0;
      if (ireq && dreq) begin
`ifdef MEM_ARB_RR_EN
        winner = last_i ? 2 : 1;
`else
        winner = 1;
`endif
      end else if (ireq) winner = 1;
      else if (dreq) winner = 2;
      if (winner != 0) begin
        own = winner;
        last_i = (winner == 1);
      end
    end else if (own == 3) begin
      if (cnt == 0) own = 0;
    end else begin
      owner_req = (own == 1) ? ireq : dreq;
      if (!owner_req) own = (cnt == 0) ? 0 : 3;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reset is raised between clock edges so its effect must appear without a clock.
  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst = 1;
    i_ren = 1; d_ren = 1;
    mem_data_valid = 1; mem_rdata = 16'hFFFF;
    #1;
    check_val("rst_grants", {30'b0, i_grant, d_grant}, 32'h0);
    check_val("rst_valids", {30'b0, i_valid, d_valid}, 32'h0);
    check_val("rst_rdata", {i_rdata, d_rdata}, 32'h0);
    check_val("rst_mem", {mem_ren, mem_wen, 14'b0, mem_addr | mem_wdata}, 32'h0);
    check_val("rst_err", {31'b0, err}, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    check_val("rst_hold", {29'b0, i_grant, d_grant, mem_ren}, 32'h0);
    #1;
    rst = 0;
    i_ren = 0; d_ren = 0; mem_data_valid = 0; mem_rdata = 0;
  endtask

  initial begin
    int ib, db;
    bit ir, iw, dr, dw;
    for (int k = 0; k < 256; k++) mem_arr[k] = 16'(k * 7 + 16'h1000);
    mute = 0;
    model_reset();
    apply_reset();

    // Lone icache read at 0x0010.
    step(1, 0, 16'h0010, 0, 0, 0, 0, 0, 0);
    step(1, 0, 16'h0010, 0, 0, 0, 0, 0, 0);
    idle_cycles(6);

    // Contention from IDLE, then icache drops and dcache takes over.
    for (int k = 0; k < 4; k++) step(1, 0, 16'h0030 + 16'(k), 0, 1, 0, 16'h0040, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 1, 0, 16'h0041, 0, 0);
    idle_cycles(6);
    // Second contention: round-robin flips the winner, fixed priority does not.
    for (int k = 0; k < 3; k++) step(1, 0, 16'h0050, 0, 1, 0, 16'h0060, 0, 0);
    idle_cycles(6);

    // Dcache write 0xBEEF to 0x0020, then read it back.
    step(0, 0, 0, 0, 0, 1, 16'h0020, 16'hBEEF, 0);
    step(0, 0, 0, 0, 0, 1, 16'h0020, 16'hBEEF, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 16'h0020, 0, 0);
    step(0, 0, 0, 0, 1, 0, 16'h0020, 0, 0);
    idle_cycles(6);

    // Icache issues 4 reads and drops while dcache waits through the drain.
    for (int k = 0; k < 5; k++) step(1, 0, 16'h0070 + 16'(k), 0, 1, 0, 16'h0080, 0, 0);
    for (int k = 0; k < 8; k++) step(0, 0, 0, 0, 1, 0, 16'h0081, 0, 0);
    // Simultaneous ren+wen: write wins.
    step(0, 0, 0, 0, 1, 1, 16'h0090, 16'h1234, 0);
    idle_cycles(6);

    // Random traffic.
    ib = 0; db = 0;
    for (int c = 0; c < 400; c++) begin
      if (ib == 0 && $urandom_range(3) == 0) ib = 1 + $urandom_range(5);
      if (db == 0 && $urandom_range(3) == 0) db = 1 + $urandom_range(5);
      iw = (ib != 0) && ($urandom_range(3) == 0);
      ir = (ib != 0) && (!iw || $urandom_range(1) == 1);
      dw = (db != 0) && ($urandom_range(3) == 0);
      dr = (db != 0) && (!dw || $urandom_range(1) == 1);
      step(ir, iw, 16'($urandom), 16'($urandom), dr, dw, 16'($urandom), 16'($urandom), 0);
      if (ib != 0) ib--;
      if (db != 0) db--;
    end
    idle_cycles(6);

    // Spurious return data while nothing is outstanding: sticky error.
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle_cycles(3);
    step(1, 0, 16'h00A0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 16'h00A0, 0, 0, 0, 0, 0, 0);
    idle_cycles(6);

    // Reset in the middle of a drain with reads still in flight.
    apply_reset();
    for (int k = 0; k < 4; k++) step(1, 0, 16'h00B0 + 16'(k), 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply_reset();
    idle_cycles(6);

    // Memory never answers: in-flight count saturates and flags overflow.
    mute = 1;
    for (int k = 0; k < 11; k++) step(1, 0, 16'h00C0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    mute = 0;
    apply_reset();
    idle_cycles(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, rising edge.
REQ-002 SHALL have: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have: i_ren, i_wen  in  1 each  icache read/write request.
REQ-004 SHALL have: i_addr, i_wdata  in  16 each  icache address/write data.
REQ-005 SHALL have: i_grant  out  1  icache owns memory.
REQ-006 SHALL have: i_valid  out  1  read data for icache this cycle.
REQ-007 SHALL have: i_rdata  out  16  icache read data.
REQ-008 SHALL have d_ren, d_wen, d_addr, d_wdata, d_grant, d_valid, d_rdata, identical to the i_* ports but for the dcache.
REQ-009 SHALL have: mem_ren, mem_wen  out  1 each  to memory4c.
REQ-010 SHALL have: mem_addr, mem_wdata  out  16 each  to memory4c.
REQ-011 SHALL have: mem_rdata  in  16  from memory4c.
REQ-012 SHALL have: mem_data_valid  in  1  from memory4c.
REQ-013 SHALL have: err  out  1  sticky protocol-error flag.

Function
REQ-014 SHALL implement FSM states IDLE, I_OWN, D_OWN, DRAIN, plus a registered last_owner bit (I/D) and a 3-bit outstanding-read counter cnt.
REQ-015 SHALL treat a requester as requesting when its ren or wen is high.
REQ-016 SHALL, in IDLE with one requester, enter that owner state next cycle; grants are registered, so the first grant follows the first request cycle by one cycle.
REQ-017 SHALL, in IDLE with both requesting, grant the icache (fixed priority; see REQ-031).
REQ-018 SHALL assert i_grant only in I_OWN and d_grant only in D_OWN; last_owner updates on each owner-state entry.
REQ-019 SHALL drive mem_ren/mem_wen/mem_addr/mem_wdata combinationally from the owner's inputs while granted, and drive all four to 0 otherwise.
REQ-020 SHALL hold the owner state while the owner requests, regardless of the other requester.
REQ-021 SHALL, when the owner drops its request, go to IDLE if the next cnt is 0, else to DRAIN.
REQ-022 SHALL leave DRAIN for IDLE in the cycle after the next cnt reaches 0; DRAIN asserts no grant.
REQ-023 SHALL increment cnt on each cycle with mem_ren=1 and mem_wen=0, decrement it on mem_data_valid, and leave it unchanged when both occur.
REQ-024 SHALL assert i_valid = mem_data_valid when (I_OWN, or DRAIN with last_owner=I), with d_valid symmetric.
REQ-025 SHALL drive i_rdata/d_rdata = mem_rdata when the matching valid is high, else 0 (no tristate).
REQ-026 SHALL set err on mem_data_valid while cnt=0 (underflow) or on an increment while cnt=7 (overflow), and SHALL saturate cnt at those bounds.
REQ-027 SHALL set err on mem_data_valid in IDLE; that data is routed to neither requester.
REQ-028 SHALL give mem_wen priority when an owner raises ren and wen together (write issued, cnt unchanged).

Reset
REQ-029 SHALL, on rst (asynchronous, mid-transaction included), force state=IDLE, cnt=0, last_owner=D, err=0; all grants, valids, rdata and mem_* outputs SHALL be 0 while rst is high.
REQ-030 SHALL issue the first grant after rst deasserts no earlier than the second rising clk edge at which a request is seen.

Configuration
REQ-031 SHALL support macro MEM_ARB_RR_EN: when defined, IDLE with both requesting grants the requester not equal to last_owner (round-robin); when undefined, the icache always wins (REQ-017).

Verification
REQ-032 Icache read at 0x0010 alone -> i_grant at cycle 2, mem_addr=0x0010, i_valid with data 4 cycles after issue, d_valid never high.
REQ-033 Both request from IDLE, macro undefined -> icache granted; d_grant only after icache drops and cnt=0; repeated, dcache starves while icache holds.
REQ-034 Both request, MEM_ARB_RR_EN defined, last_owner=I -> dcache granted first; next contention grants icache.
REQ-035 Icache issues 4 reads then drops -> DRAIN; all 4 valids go to i_valid; a pending d request is granted only after the 4th valid, and d_grant is never high in DRAIN.
REQ-036 Dcache write 0xBEEF to 0x0020 -> mem_wen=1, mem_wdata=0xBEEF, cnt stays 0; returns to IDLE the cycle after d_wen drops.
REQ-037 Spurious mem_data_valid with cnt=0 -> err=1 until rst; rst asserted in DRAIN with cnt=3 -> immediate IDLE, cnt=0, outputs 0.
